// File: rtl/gesture_pkg.sv
// Shared types and width helpers for the gesture template matcher.
package gesture_pkg;

   typedef enum logic [1:0] {LOAD, RUN, DRAIN, OUT} state_t;

   localparam int VEC_DW = 6;

   typedef struct packed {
      logic signed [VEC_DW-1:0] x;
      logic signed [VEC_DW-1:0] y;
   } vec_t;

   // Score width that holds VEC_LEN worst-case two-term products without overflow.
   function automatic int acc_w(input int dw, input int vec_len);
      return 2*dw + 1 + $clog2(vec_len);
   endfunction

endpackage

// File: rtl/dot2_mac.sv
// Two-term signed dot product with a registered accumulator; restart loads the term alone.
module dot2_mac
   import gesture_pkg::*;
#(
   parameter int DW    = 6,
   parameter int ACC_W = acc_w(6, 16)
) (
   input  logic                    i_clk,
   input  logic                    en,
   input  logic                    restart,
   input  logic signed [DW-1:0]    a_x,
   input  logic signed [DW-1:0]    a_y,
   input  logic signed [DW-1:0]    b_x,
   input  logic signed [DW-1:0]    b_y,
   output logic signed [ACC_W-1:0] acc_next
);

   logic signed [2*DW-1:0]  ax_e, ay_e, bx_e, by_e;
   logic signed [2*DW-1:0]  prod_x, prod_y;
   logic signed [2*DW:0]    term;
   logic signed [ACC_W-1:0] term_e;
   logic signed [ACC_W-1:0] acc;

   always_comb begin
      ax_e   = {{DW{a_x[DW-1]}}, a_x};
      ay_e   = {{DW{a_y[DW-1]}}, a_y};
      bx_e   = {{DW{b_x[DW-1]}}, b_x};
      by_e   = {{DW{b_y[DW-1]}}, b_y};
      prod_x = ax_e * bx_e;
      prod_y = ay_e * by_e;
      term   = {prod_x[2*DW-1], prod_x} + {prod_y[2*DW-1], prod_y};
      term_e = {{(ACC_W-2*DW-1){term[2*DW]}}, term};
      acc_next = restart ? term_e : acc + term_e;
   end

   always_ff @(posedge i_clk) begin
      if (en) acc <= acc_next;
   end

endmodule

// File: rtl/gesture_matcher.sv
// Buffers a window of motion vectors, scores it against every library template by dot
// product and reports the best class, its score and a threshold match.
module gesture_matcher
   import gesture_pkg::*;
#(
   parameter int N_CLASS = 26,
   parameter int VEC_LEN = 16,
   parameter int DW      = 6,
   parameter int IDX_W   = $clog2(N_CLASS),
   parameter int ADDR_W  = $clog2(N_CLASS*VEC_LEN),
   parameter int ACC_W   = acc_w(DW, VEC_LEN)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_clear,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic signed [DW-1:0]    i_vec_x,
   input  logic signed [DW-1:0]    i_vec_y,
   output logic [ADDR_W-1:0]       o_lib_addr,
   input  logic signed [DW-1:0]    i_lib_x,
   input  logic signed [DW-1:0]    i_lib_y,
   input  logic signed [ACC_W-1:0] i_thresh,
   output logic                    o_valid,
   output logic [IDX_W-1:0]        o_index,
   output logic signed [ACC_W-1:0] o_score,
   output logic                    o_match
);

   localparam int T   = N_CLASS*VEC_LEN;
   localparam int K_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

   state_t                  state, state_nxt;
   logic [K_W-1:0]          k, k_p1;
   logic [IDX_W-1:0]        cls, cls_p1, best_idx, fin_idx;
   logic [ADDR_W-1:0]       addr;
   logic                    vld_p1, first_p1, last_p1;
   logic                    accept, k_last, addr_last, take, match_q;
   logic signed [DW-1:0]    win_x [VEC_LEN];
   logic signed [DW-1:0]    win_y [VEC_LEN];
   logic signed [ACC_W-1:0] acc_next, best_score, fin_score;

   assign o_ready    = (state == LOAD);
   assign o_valid    = (state == OUT);
   assign o_lib_addr = addr;
   assign accept     = o_ready && i_valid && !i_clear;
   assign k_last     = (k == K_W'(VEC_LEN-1));
   assign addr_last  = (addr == ADDR_W'(T-1));

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (accept && k_last) state_nxt = RUN;
         RUN:     if (addr_last) state_nxt = DRAIN;
         DRAIN:   state_nxt = OUT;
         OUT:     state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
      if (i_clear) state_nxt = LOAD;
   end

   // p0: address/counter stage; k doubles as the window fill count while loading
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= LOAD;
         k        <= '0;
         cls      <= '0;
         addr     <= '0;
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
         k_p1     <= '0;
         cls_p1   <= '0;
      end else begin
         state    <= state_nxt;
         vld_p1   <= (state == RUN) && !i_clear;
         first_p1 <= (k == '0);
         last_p1  <= k_last;
         k_p1     <= k;
         cls_p1   <= cls;
         if (i_clear) begin
            k    <= '0;
            cls  <= '0;
            addr <= '0;
         end else if (state == LOAD) begin
            if (accept) k <= k_last ? '0 : k + 1'b1;
         end else if (state == RUN) begin
            k    <= k_last ? '0 : k + 1'b1;
            addr <= addr_last ? '0 : addr + 1'b1;
            if (addr_last)   cls <= '0;
            else if (k_last) cls <= cls + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         win_x[k] <= i_vec_x;
         win_y[k] <= i_vec_y;
      end
   end

   // p1: library data for the previous address meets the buffered vector
   dot2_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
      .i_clk    (i_clk),
      .en       (vld_p1),
      .restart  (first_p1),
      .a_x      (win_x[k_p1]),
      .a_y      (win_y[k_p1]),
      .b_x      (i_lib_x),
      .b_y      (i_lib_y),
      .acc_next (acc_next)
   );

   // Class 0 seeds the tracker unconditionally; later classes need a strictly larger score.
   assign take      = vld_p1 && last_p1 && ((cls_p1 == '0) || (acc_next > best_score));
   assign fin_score = take ? acc_next : best_score;
   assign fin_idx   = take ? cls_p1 : best_idx;

   always_ff @(posedge i_clk) begin
      if (take) begin
         best_score <= acc_next;
         best_idx   <= cls_p1;
      end
   end

   // p2: result registers, loaded as the final class completes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_index <= '0;
         o_score <= '0;
         match_q <= 1'b0;
      end else begin
         if (state == DRAIN && !i_clear) begin
            o_index <= fin_idx;
            o_score <= fin_score;
         end
         if (state == OUT) match_q <= o_match;
      end
   end

   assign o_match = (state == OUT) ? (o_score >= i_thresh) : match_q;

endmodule

// File: tb/tb_gesture_matcher.sv
// Randomized and directed bench for gesture_matcher against a plain-arithmetic score model.
module tb_gesture_matcher;
   import gesture_pkg::*;

   localparam int NC = 4;
   localparam int VL = 2;
   localparam int T  = NC*VL;

   logic              clk, rst_n, clear, valid, ready;
   logic signed [5:0] vx, vy, lib_x, lib_y;
   logic [2:0]        lib_addr;
   logic signed [13:0] thresh, score;
   logic              ovalid, match;
   logic [1:0]        index;

   logic              d_valid, d_ready, d_ovalid, d_match;
   logic signed [5:0] d_vx, d_vy, d_lib_x, d_lib_y;
   logic [8:0]        d_addr;
   logic signed [16:0] d_thresh, d_score;
   logic [4:0]        d_index;

   logic signed [5:0] mem_x [T];
   logic signed [5:0] mem_y [T];
   vec_t              win [VL];

   int checks = 0;
   int errors = 0;

   gesture_matcher #(.N_CLASS(NC), .VEC_LEN(VL), .DW(6)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid), .o_ready(ready),
      .i_vec_x(vx), .i_vec_y(vy), .o_lib_addr(lib_addr), .i_lib_x(lib_x), .i_lib_y(lib_y),
      .i_thresh(thresh), .o_valid(ovalid), .o_index(index), .o_score(score), .o_match(match)
   );

   gesture_matcher dut_d (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_valid(d_valid), .o_ready(d_ready),
      .i_vec_x(d_vx), .i_vec_y(d_vy), .o_lib_addr(d_addr), .i_lib_x(d_lib_x), .i_lib_y(d_lib_y),
      .i_thresh(d_thresh), .o_valid(d_ovalid), .o_index(d_index), .o_score(d_score),
      .o_match(d_match)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      lib_x <= mem_x[lib_addr];
      lib_y <= mem_y[lib_addr];
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: score every class as a plain sum of products, keep the first maximum.
   task automatic model(output int ei, output longint es);
      longint s;
      ei = 0;
      es = 0;
      for (int c = 0; c < NC; c++) begin
         s = 0;
         for (int k = 0; k < VL; k++)
            s += longint'($signed(win[k].x)) * longint'(mem_x[c*VL+k])
               + longint'($signed(win[k].y)) * longint'(mem_y[c*VL+k]);
         if (c == 0 || s > es) begin
            es = s;
            ei = c;
         end
      end
   endtask

   task automatic clear_lib();
      for (int a = 0; a < T; a++) begin
         mem_x[a] = 0;
         mem_y[a] = 0;
      end
   endtask

   task automatic set_win(input int x0, input int y0, input int x1, input int y1);
      win[0].x = 6'(x0); win[0].y = 6'(y0);
      win[1].x = 6'(x1); win[1].y = 6'(y1);
   endtask

   task automatic send_window(input int gap_max);
      for (int k = 0; k < VL; k++) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(negedge clk);
            valid = 1'b0;
         end
         @(negedge clk);
         valid = 1'b1;
         vx = win[k].x;
         vy = win[k].y;
      end
   endtask

   task automatic wait_result(input string tag, input int ei, input longint es,
                              input bit em, input bit junk);
      int lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (junk) begin
            valid = 1'($urandom);
            vx = 6'($urandom);
            vy = 6'($urandom);
         end else begin
            valid = 1'b0;
         end
      end while (!ovalid && lat < 100);
      valid = 1'b0;
      check({tag, "_latency"}, lat, T + 2);
      check({tag, "_index"}, index, ei);
      check({tag, "_score"}, longint'(score), es);
      check({tag, "_match"}, match, em);
      @(negedge clk);
      check({tag, "_pulse"}, ovalid, 0);
      check({tag, "_held"}, index, ei);
      check({tag, "_match_held"}, match, em);
      check({tag, "_addr_idle"}, lib_addr, 0);
      check({tag, "_ready"}, ready, 1);
   endtask

   initial begin
      int     ei, lat, mode;
      longint es;
      bit     saw;
      clk = 0; rst_n = 0; clear = 0; valid = 0; vx = 0; vy = 0; thresh = 0;
      d_valid = 0; d_vx = 0; d_vy = 0; d_lib_x = -6'sd32; d_lib_y = -6'sd32;
      d_thresh = 17'sd32768;
      clear_lib();
      repeat (3) @(negedge clk);
      check("rst_valid", ovalid, 0);
      check("rst_index", index, 0);
      check("rst_score", longint'(score), 0);
      check("rst_match", match, 0);
      check("rst_addr", lib_addr, 0);
      check("rst_ready", ready, 1);
      rst_n = 1;

      // single dominant template
      clear_lib();
      mem_x[4] = 5; mem_x[5] = 5;
      set_win(1, 0, 1, 0);
      thresh = 14'sd8;
      send_window(2);
      wait_result("t1", 2, 10, 1, 1'b0);

      // tie between classes 1 and 3 keeps the lower index
      clear_lib();
      mem_x[2] = 3; mem_x[3] = 4; mem_x[6] = 7;
      send_window(0);
      wait_result("t2", 1, 7, 0, 1'b1);

      // all scores negative
      clear_lib();
      mem_x[0] = -9; mem_x[2] = -4; mem_x[4] = -6; mem_x[6] = -12;
      set_win(1, 0, 0, 0);
      thresh = 0;
      send_window(1);
      wait_result("t3", 1, -4, 0, 1'b1);

      // abort mid-run, then a clear colliding with an accept
      clear_lib();
      mem_x[4] = 5; mem_x[5] = 5;
      set_win(1, 0, 1, 0);
      thresh = 14'sd8;
      send_window(0);
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      check("clr_ready", ready, 1);
      check("clr_keep_index", index, 1);
      valid = 1'b1; vx = 6'sd31; vy = 6'sd31;
      @(negedge clk);
      clear = 1'b0;
      valid = 1'b0;
      saw = 0;
      repeat (12) begin
         @(negedge clk);
         if (ovalid) saw = 1;
      end
      check("clr_no_valid", saw, 0);
      send_window(1);
      wait_result("t5", 2, 10, 1, 1'b0);

      // asynchronous reset mid-run
      clear_lib();
      mem_x[2] = -3; mem_y[3] = 2; mem_x[6] = 1;
      set_win(2, -1, 0, 5);
      send_window(0);
      @(negedge clk);
      valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_valid", ovalid, 0);
      check("arst_index", index, 0);
      check("arst_score", longint'(score), 0);
      check("arst_match", match, 0);
      check("arst_addr", lib_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model(ei, es);
      thresh = 14'(es);
      send_window(1);
      wait_result("t6", ei, es, 1, 1'b0);

      // random windows and templates; threshold placed at score-1, score, score+1
      for (int it = 0; it < 25; it++) begin
         for (int a = 0; a < T; a++) begin
            mem_x[a] = 6'($urandom);
            mem_y[a] = 6'($urandom);
         end
         for (int k = 0; k < VL; k++) begin
            win[k].x = 6'($urandom);
            win[k].y = 6'($urandom);
         end
         model(ei, es);
         mode = int'($urandom_range(0, 2));
         thresh = 14'(es + longint'(mode - 1));
         send_window(3);
         wait_result("rand", ei, es, mode <= 1, 1'b1);
      end

      // default-size instance at the extreme input corner
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         d_valid = 1'b1;
         d_vx = -6'sd32;
         d_vy = -6'sd32;
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         d_valid = 1'b0;
      end while (!d_ovalid && lat < 1000);
      check("dflt_latency", lat, 26*16 + 2);
      check("dflt_index", d_index, 0);
      check("dflt_score", longint'(d_score), 32768);
      check("dflt_match", d_match, 1);
      @(negedge clk);
      check("dflt_pulse", d_ovalid, 0);
      check("dflt_addr_idle", d_addr, 0);
      check("dflt_ready", d_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
